load_store_unit: RTL and testbench
==================================

# load_store_unit

MEM-stage load/store unit for the 5-stage RV64 pipeline. It sits between the EX/MEM register and the data memory. It accepts one load or store per handshake from EX and drives a variable-latency request/acknowledge data-memory port. It performs byte-lane alignment, byte-enable generation, load sign/zero extension and misalignment detection, then returns a one-cycle response (register index, data, write-enable) to WB.

## Interface
- ADDR_W, 32, byte-address width of requests and of the data-memory port
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  EX presents a memory operation
- req_ready_o  output  1  unit can accept a request; low means stall EX and earlier stages
- req_we_i  input  1  1 = store, 0 = load
- req_funct3_i  input  3  RISC-V funct3 (size/sign)
- req_addr_i  input  ADDR_W  byte address (ALU result)
- req_wdata_i  input  64  store data (rs2 value), right-justified
- req_rd_i  input  5  destination register for loads
- dmem_req_o  output  1  memory access request, held until ack
- dmem_we_o  output  1  write strobe
- dmem_addr_o  output  ADDR_W  doubleword-aligned address (bits [2:0] = 0)
- dmem_be_o  output  8  byte enables, bit i = byte lane i
- dmem_wdata_o  output  64  lane-shifted store data
- dmem_ack_i  input  1  memory completes access this cycle
- dmem_rdata_i  input  64  read doubleword, valid when dmem_ack_i=1
- resp_valid_o  output  1  one-cycle response pulse to WB
- resp_we_o  output  1  WB writes resp_data_o to resp_rd_o
- resp_rd_o  output  5  destination register
- resp_data_o  output  64  extended load data (0 for stores/faults)
- fault_o  output  1  misaligned or illegal access, qualified by resp_valid_o

## Operation
- States: IDLE, ACCESS. Reset forces IDLE.
- req_ready_o = (state == IDLE). This is combinational from state only, with no dependence on req_valid_i.
- Accept occurs on a rising edge with req_valid_i & req_ready_o. The unit registers we, funct3, addr[2:0], rd and lane data.
- Sizes:
  - funct3[1:0]: 00 byte, 01 half, 10 word, 11 double.
  - funct3[2]=1 means zero-extend and is legal for loads only (100, 101, 110).
  - Illegal combinations are a load with 111, or a store with funct3[2]=1.
- Alignment:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - double requires addr[2:0]=0.
  - byte is always aligned.
- Fault path (misaligned or illegal): no memory access. State stays IDLE. Next cycle resp_valid_o=1, fault_o=1, resp_we_o=0, resp_data_o=0.
- Normal path: state goes to ACCESS. Outputs in ACCESS:
  - dmem_req_o=1.
  - dmem_addr_o = {addr[ADDR_W-1:3],3'b0}.
  - dmem_be_o = mask << addr[2:0], where mask is 01, 03, 0F or FF by size.
  - dmem_wdata_o = req_wdata_i << (8*addr[2:0]).
  - dmem_we_o = req_we_i.
- All dmem_* outputs are registered and stay stable throughout ACCESS. dmem_be_o and dmem_wdata_o are 0 outside ACCESS.
- On an edge where ACCESS and dmem_ack_i=1: state returns to IDLE and the response is registered.
  - Load: shifted = dmem_rdata_i >> (8*off). The value is then sign- or zero-extended from 8/16/32 bits; double is passed through. resp_we_o=1.
  - Store: resp_data_o=0, resp_we_o=0.
- resp_we_o=1 with resp_rd_o=0 is legal; the register file ignores writes to x0.
- dmem_ack_i is ignored outside ACCESS. dmem_rdata_i is don't-care without ack.
- Only one access is ever outstanding.

## Timing
- Reset values: req_ready_o=1 and every other output = 0. The state machine is IDLE.
- Reset asserted mid-ACCESS: dmem_req_o drops immediately (asynchronous). The access is abandoned with no response. A late ack after release is ignored.
- Latency for an accept at edge E0 with ack sampled at edge Ek (k≥1):
  - dmem_req_o is high from E0 to Ek.
  - resp_valid_o is high for exactly one cycle after Ek.
  - Minimum accept-to-response is 2 edges.
- Back-to-back: req_ready_o is 1 in the cycle after Ek, so a new request can be accepted at Ek+1 while resp_valid_o for the previous one is high.
- Throughput: one access per 2 cycles with zero-wait memory. One fault response per cycle.
- resp_valid_o is never high for two consecutive cycles from the same request. WB always accepts; there is no backpressure.

## Test plan
- Sign extension: lb at 0x1007 (funct3 000), ack at first ACCESS edge, rdata 0x8877665544332211. Required: dmem_addr 0x1000, be 0x80, then resp_data 0xFFFFFFFFFFFFFF88, resp_we=1, 2-edge latency.
- Zero/sign extension: lhu at 0x1006 with the same rdata gives 0x0000000000008877. lw at 0x1004 gives 0xFFFFFFFF88776655. lwu at 0x1004 gives 0x0000000088776655.
- Store: sw at 0x1004, wdata 0xDEADBEEF, ack after 3 wait cycles. Required:
  - dmem_req high for 4 cycles, be 0xF0, dmem_wdata[63:32]=0xDEADBEEF, all stable throughout.
  - Then resp_valid with resp_we=0; req_ready low throughout ACCESS.
- Faults: sh at 0x1003, ld at 0x1004, and a store with funct3 100. Each gives no dmem_req, and next cycle resp_valid=1, fault_o=1, resp_we=0.
- Back-to-back: req_valid held with two loads, zero-wait memory. The second accept lands on the edge after the first ack. The two responses are 2 cycles apart.
- Reset mid-ACCESS: rst low while dmem_req=1, then ack pulsed after release. Required: dmem_req=0 immediately, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, data-memory and writeback signals of the MEM-stage load/store unit.
// The unit itself uses the slave view; its environment uses the master view.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [2:0]        req_funct3_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [63:0]       req_wdata_i;
  logic [4:0]        req_rd_i;

  logic              dmem_req_o;
  logic              dmem_we_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic [7:0]        dmem_be_o;
  logic [63:0]       dmem_wdata_o;
  logic              dmem_ack_i;
  logic [63:0]       dmem_rdata_i;

  logic              resp_valid_o;
  logic              resp_we_o;
  logic [4:0]        resp_rd_o;
  logic [63:0]       resp_data_o;
  logic              fault_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    input  dmem_ack_i, dmem_rdata_i,
    output req_ready_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output resp_valid_o, resp_we_o, resp_rd_o, resp_data_o, fault_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    output dmem_ack_i, dmem_rdata_i,
    input  req_ready_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  resp_valid_o, resp_we_o, resp_rd_o, resp_data_o, fault_o
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: lane alignment, byte enables, load extension and
// misalignment detection in front of a variable-latency req/ack data memory.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [2:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        be_q, be_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_we_q, resp_we_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic [63:0]       resp_data_q, resp_data_d;
  logic              fault_q, fault_d;

  logic [7:0]        size_mask;
  logic              misaligned;
  logic              illegal;
  logic              accept;
  logic [63:0]       shifted;
  logic [63:0]       load_data;

  always_comb begin
    size_mask  = 8'hFF;
    misaligned = 1'b0;
    unique case (bus.req_funct3_i[1:0])
      2'b00: begin size_mask = 8'h01; misaligned = 1'b0; end
      2'b01: begin size_mask = 8'h03; misaligned = bus.req_addr_i[0]; end
      2'b10: begin size_mask = 8'h0F; misaligned = |bus.req_addr_i[1:0]; end
      default: begin size_mask = 8'hFF; misaligned = |bus.req_addr_i[2:0]; end
    endcase
    illegal = bus.req_we_i ? bus.req_funct3_i[2] : (bus.req_funct3_i == 3'b111);
    accept  = bus.req_valid_i && (state_q == IDLE);
  end

  always_comb begin
    shifted   = bus.dmem_rdata_i >> {off_q, 3'b000};
    load_data = '0;
    unique case (funct3_q)
      3'b000:  load_data = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_data = shifted;
      3'b100:  load_data = {56'd0, shifted[7:0]};
      3'b101:  load_data = {48'd0, shifted[15:0]};
      3'b110:  load_data = {32'd0, shifted[31:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_rd_d    = '0;
    resp_data_d  = '0;
    fault_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal || misaligned) begin
            // Faulting requests never leave IDLE; the response alone reports them.
            resp_valid_d = 1'b1;
            fault_d      = 1'b1;
            resp_rd_d    = bus.req_rd_i;
          end else begin
            state_d  = ACCESS;
            we_d     = bus.req_we_i;
            funct3_d = bus.req_funct3_i;
            off_d    = bus.req_addr_i[2:0];
            rd_d     = bus.req_rd_i;
            addr_d   = {bus.req_addr_i[ADDR_W-1:3], 3'b000};
            be_d     = size_mask << bus.req_addr_i[2:0];
            wdata_d  = bus.req_wdata_i << {bus.req_addr_i[2:0], 3'b000};
          end
        end
      end
      ACCESS: begin
        if (bus.dmem_ack_i) begin
          state_d      = IDLE;
          we_d         = 1'b0;
          addr_d       = '0;
          be_d         = '0;
          wdata_d      = '0;
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          resp_we_d    = !we_q;
          resp_data_d  = we_q ? '0 : load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.dmem_req_o   = (state_q == ACCESS);
  assign bus.dmem_we_o    = we_q;
  assign bus.dmem_addr_o  = addr_q;
  assign bus.dmem_be_o    = be_q;
  assign bus.dmem_wdata_o = wdata_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_we_o    = resp_we_q;
  assign bus.resp_rd_o    = resp_rd_q;
  assign bus.resp_data_o  = resp_data_q;
  assign bus.fault_o      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_load_store_unit;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();
  load_store_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ready_before;
    logic        req_seen;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        we;
    int unsigned req_cycles;
    logic        stable;
    logic        ready_low;
    int unsigned latency;
    logic        resp_valid;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [63:0] resp_data;
    logic        fault;
    logic        req_after;
    logic [7:0]  be_after;
    logic [63:0] wdata_after;
    logic        resp_valid_after;
  } op_obs_t;

  // Reference model: sizes, lanes and extension from plain arithmetic.
  function automatic int unsigned op_bytes(logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic logic model_fault(logic we, logic [2:0] f3, logic [31:0] a);
    if (we && f3[2]) return 1'b1;
    if (!we && f3 == 3'b111) return 1'b1;
    return (a % op_bytes(f3)) != 0;
  endfunction

  function automatic logic [7:0] model_be(logic [2:0] f3, logic [31:0] a);
    int unsigned off;
    logic [7:0] be;
    off = a % 8;
    be = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (i >= off && i < off + op_bytes(f3)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [63:0] model_wdata(logic [63:0] wd, logic [31:0] a);
    longint unsigned v;
    int unsigned off;
    off = a % 8;
    v = wd;
    return v * (64'd1 << (8 * off));
  endfunction

  function automatic logic [63:0] model_load(logic [2:0] f3, logic [31:0] a, logic [63:0] rdata);
    int unsigned n;
    int unsigned off;
    longint unsigned v;
    longint unsigned lim;
    n = op_bytes(f3);
    off = a % 8;
    v = rdata;
    v = v / (64'd1 << (8 * off));
    if (n == 8) return v;
    lim = 64'd1 << (8 * n);
    v = v % lim;
    if (!f3[2] && v >= lim / 2) v = v - lim;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [4:0] rd, input int unsigned waits,
                        input logic [63:0] rdata, output op_obs_t o);
    o = '{default: '0};
    o.ready_before = bus.req_ready_o;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    bus.req_rd_i     = rd;
    tick();
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = $urandom;
    bus.req_wdata_i  = {$urandom, $urandom};
    bus.req_funct3_i = 3'($urandom);
    o.latency   = 1;
    o.req_seen  = bus.dmem_req_o;
    o.addr      = bus.dmem_addr_o;
    o.be        = bus.dmem_be_o;
    o.wdata     = bus.dmem_wdata_o;
    o.we        = bus.dmem_we_o;
    o.stable    = 1'b1;
    o.ready_low = 1'b1;
    if (o.req_seen) begin
      for (int unsigned w = 0; w <= waits; w++) begin
        if (bus.dmem_req_o !== 1'b1 || bus.dmem_addr_o !== o.addr || bus.dmem_be_o !== o.be ||
            bus.dmem_wdata_o !== o.wdata || bus.dmem_we_o !== o.we || bus.resp_valid_o !== 1'b0)
          o.stable = 1'b0;
        if (bus.req_ready_o !== 1'b0) o.ready_low = 1'b0;
        o.req_cycles++;
        bus.dmem_ack_i   = (w == waits);
        bus.dmem_rdata_i = (w == waits) ? rdata : {$urandom, $urandom};
        tick();
        o.latency++;
      end
      bus.dmem_ack_i   = 1'b0;
      bus.dmem_rdata_i = {$urandom, $urandom};
    end
    o.resp_valid  = bus.resp_valid_o;
    o.resp_we     = bus.resp_we_o;
    o.resp_rd     = bus.resp_rd_o;
    o.resp_data   = bus.resp_data_o;
    o.fault       = bus.fault_o;
    o.req_after   = bus.dmem_req_o;
    o.be_after    = bus.dmem_be_o;
    o.wdata_after = bus.dmem_wdata_o;
    tick();
    o.resp_valid_after = bus.resp_valid_o;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = '0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_rd_i = '0;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = '0;
    tick(); tick();
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o);
    end
    checks++;
    if ({bus.dmem_req_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o, bus.dmem_wdata_o,
         bus.resp_valid_o, bus.resp_we_o, bus.resp_rd_o, bus.resp_data_o, bus.fault_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%h wd=%h rv=%b rwe=%b rd=%0d rdata=%h flt=%b want all 0",
               bus.dmem_req_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_be_o, bus.dmem_wdata_o,
               bus.resp_valid_o, bus.resp_we_o, bus.resp_rd_o, bus.resp_data_o, bus.fault_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [4] = '{3'b000, 3'b101, 3'b010, 3'b110};
    logic [31:0] ads [4] = '{32'h1007, 32'h1006, 32'h1004, 32'h1004};
    logic [7:0]  bes [4] = '{8'h80, 8'hC0, 8'hF0, 8'hF0};
    logic [63:0] exp [4] = '{64'hFFFFFFFFFFFFFF88, 64'h0000000000008877,
                            64'hFFFFFFFF88776655, 64'h0000000088776655};
    op_obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f3s[i], ads[i], 64'h0, 5'(i + 1), 0, 64'h8877665544332211, o);
      checks++;
      if (o.addr !== 32'h1000 || o.be !== bes[i] || o.we !== 1'b0 || o.req_seen !== 1'b1) begin
        errors++; $display("FAIL load%0d_dmem: got req=%b addr=%h be=%h we=%b want 1 00001000 %h 0",
                           i, o.req_seen, o.addr, o.be, o.we, bes[i]);
      end
      checks++;
      if (o.resp_valid !== 1'b1 || o.resp_data !== exp[i] || o.resp_we !== 1'b1 ||
          o.fault !== 1'b0 || o.resp_rd !== 5'(i + 1)) begin
        errors++; $display("FAIL load%0d_resp: got v=%b data=%h we=%b flt=%b rd=%0d want 1 %h 1 0 %0d",
                           i, o.resp_valid, o.resp_data, o.resp_we, o.fault, o.resp_rd, exp[i], i + 1);
      end
      checks++;
      if (o.latency != 2 || o.resp_valid_after !== 1'b0 || o.ready_before !== 1'b1) begin
        errors++; $display("FAIL load%0d_timing: got latency=%0d v_after=%b want 2 0",
                           i, o.latency, o.resp_valid_after);
      end
    end
  endtask

  task automatic test_store_wait();
    op_obs_t o;
    run_op(1'b1, 3'b010, 32'h1004, 64'h00000000DEADBEEF, 5'd9, 3, 64'h0, o);
    checks++;
    if (o.req_cycles != 4 || o.stable !== 1'b1 || o.ready_low !== 1'b1) begin
      errors++; $display("FAIL store_hold: got cycles=%0d stable=%b ready_low=%b want 4 1 1",
                         o.req_cycles, o.stable, o.ready_low);
    end
    checks++;
    if (o.be !== 8'hF0 || o.wdata[63:32] !== 32'hDEADBEEF || o.we !== 1'b1 || o.addr !== 32'h1000) begin
      errors++; $display("FAIL store_lanes: got be=%h wd=%h we=%b addr=%h want F0 DEADBEEF_xxxxxxxx 1 00001000",
                         o.be, o.wdata, o.we, o.addr);
    end
    checks++;
    if (o.resp_valid !== 1'b1 || o.resp_we !== 1'b0 || o.resp_data !== 64'h0 || o.fault !== 1'b0 ||
        o.latency != 5) begin
      errors++; $display("FAIL store_resp: got v=%b we=%b data=%h flt=%b lat=%0d want 1 0 0 0 5",
                         o.resp_valid, o.resp_we, o.resp_data, o.fault, o.latency);
    end
    checks++;
    if (o.req_after !== 1'b0 || o.be_after !== 8'h0 || o.wdata_after !== 64'h0) begin
      errors++; $display("FAIL store_idle_lanes: got req=%b be=%h wd=%h want 0 0 0",
                         o.req_after, o.be_after, o.wdata_after);
    end
  endtask

  task automatic test_faults();
    logic        wes [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [4] = '{3'b001, 3'b011, 3'b100, 3'b111};
    logic [31:0] ads [4] = '{32'h1003, 32'h1004, 32'h1000, 32'h1000};
    op_obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_op(wes[i], f3s[i], ads[i], {$urandom, $urandom}, 5'd7, 0, 64'h0, o);
      checks++;
      if (o.req_seen !== 1'b0 || o.resp_valid !== 1'b1 || o.fault !== 1'b1 || o.resp_we !== 1'b0 ||
          o.resp_data !== 64'h0 || o.resp_valid_after !== 1'b0) begin
        errors++; $display("FAIL fault%0d: got req=%b v=%b flt=%b we=%b data=%h v_after=%b want 0 1 1 0 0 0",
                           i, o.req_seen, o.resp_valid, o.fault, o.resp_we, o.resp_data, o.resp_valid_after);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rda, rdb, expa, expb;
    rda = {$urandom, $urandom};
    rdb = {$urandom, $urandom};
    expa = model_load(3'b011, 32'h2000, rda);
    expb = model_load(3'b100, 32'h2003, rdb);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b011;
    bus.req_addr_i = 32'h2000; bus.req_rd_i = 5'd3;
    tick();
    bus.req_funct3_i = 3'b100; bus.req_addr_i = 32'h2003; bus.req_rd_i = 5'd4;
    checks++;
    if (bus.dmem_req_o !== 1'b1 || bus.req_ready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_first_access: got req=%b ready=%b want 1 0", bus.dmem_req_o, bus.req_ready_o);
    end
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = rda;
    tick();
    bus.dmem_ack_i = 1'b0;
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== expa || bus.resp_rd_o !== 5'd3 ||
        bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_first_resp: got v=%b data=%h rd=%0d ready=%b want 1 %h 3 1",
                         bus.resp_valid_o, bus.resp_data_o, bus.resp_rd_o, bus.req_ready_o, expa);
    end
    tick();
    bus.req_valid_i = 1'b0;
    checks++;
    if (bus.dmem_req_o !== 1'b1 || bus.dmem_addr_o !== 32'h2000 || bus.dmem_be_o !== 8'h08 ||
        bus.resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept: got req=%b addr=%h be=%h v=%b want 1 00002000 08 0",
                         bus.dmem_req_o, bus.dmem_addr_o, bus.dmem_be_o, bus.resp_valid_o);
    end
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = rdb;
    tick();
    bus.dmem_ack_i = 1'b0;
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== expb || bus.resp_rd_o !== 5'd4) begin
      errors++; $display("FAIL b2b_second_resp: got v=%b data=%h rd=%0d want 1 %h 4",
                         bus.resp_valid_o, bus.resp_data_o, bus.resp_rd_o, expb);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    int unsigned seen;
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b010;
    bus.req_addr_i = 32'h3000; bus.req_rd_i = 5'd5;
    tick();
    bus.req_valid_i = 1'b0;
    checks++;
    if (bus.dmem_req_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup: got req=%b want 1", bus.dmem_req_o);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got req=%b ready=%b v=%b want 0 1 0",
                         bus.dmem_req_o, bus.req_ready_o, bus.resp_valid_o);
    end
    tick();
    rst = 1'b1;
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = {$urandom, $urandom};
    tick();
    bus.dmem_ack_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid_o !== 1'b0 || bus.dmem_req_o !== 1'b0 || bus.req_ready_o !== 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_mid_late_ack: got %0d bad cycles want 0", seen);
    end
  endtask

  task automatic test_random();
    op_obs_t o;
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    logic [63:0] wd, rdata, exp_data;
    logic [4:0] rd;
    int unsigned waits;
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom); f3 = 3'($urandom); a = $urandom;
      wd = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      rd = 5'($urandom); waits = $urandom_range(0, 3);
      run_op(we, f3, a, wd, rd, waits, rdata, o);
      if (model_fault(we, f3, a)) begin
        checks++;
        if (o.req_seen !== 1'b0 || o.resp_valid !== 1'b1 || o.fault !== 1'b1 || o.resp_we !== 1'b0 ||
            o.resp_data !== 64'h0) begin
          errors++; $display("FAIL rand%0d_fault: we=%b f3=%b a=%h got req=%b v=%b flt=%b rwe=%b data=%h want 0 1 1 0 0",
                             n, we, f3, a, o.req_seen, o.resp_valid, o.fault, o.resp_we, o.resp_data);
        end
      end else begin
        exp_data = we ? 64'h0 : model_load(f3, a, rdata);
        checks++;
        if (o.req_seen !== 1'b1 || o.addr !== {a[31:3], 3'b000} || o.be !== model_be(f3, a) ||
            o.wdata !== model_wdata(wd, a) || o.we !== we || o.stable !== 1'b1) begin
          errors++; $display("FAIL rand%0d_dmem: we=%b f3=%b a=%h got req=%b addr=%h be=%h wd=%h we=%b st=%b want 1 %h %h %h %b 1",
                             n, we, f3, a, o.req_seen, o.addr, o.be, o.wdata, o.we, o.stable,
                             {a[31:3], 3'b000}, model_be(f3, a), model_wdata(wd, a), we);
        end
        checks++;
        if (o.resp_valid !== 1'b1 || o.fault !== 1'b0 || o.resp_we !== !we || o.resp_rd !== rd ||
            o.resp_data !== exp_data || o.latency != waits + 2 || o.resp_valid_after !== 1'b0) begin
          errors++; $display("FAIL rand%0d_resp: we=%b f3=%b a=%h got v=%b flt=%b rwe=%b rd=%0d data=%h lat=%0d want 1 0 %b %0d %h %0d",
                             n, we, f3, a, o.resp_valid, o.fault, o.resp_we, o.resp_rd, o.resp_data,
                             o.latency, !we, rd, exp_data, waits + 2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_wait();
    test_faults();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
